// File: rtl/alu_ctrl_sequencer_pkg.sv
// rtl/alu_ctrl_sequencer_pkg.sv - shared encodings for the ALU-class control sequencer
package alu_ctrl_sequencer_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WBLATCH = 3'd4;
    localparam logic [2:0] S_WBWRITE = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;
    localparam logic [2:0] S_TRAP    = 3'd7;

    localparam int IR_OP_HI = 31;
    localparam int IR_OP_LO = 27;
    localparam int IR_RA_HI = 26;
    localparam int IR_RA_LO = 23;
    localparam int IR_RB_HI = 22;
    localparam int IR_RB_LO = 19;
    localparam int IR_RC_HI = 18;
    localparam int IR_RC_LO = 15;

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHRA = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_ROR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_AND  = 5'd10;
    localparam logic [4:0] OP_OR   = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [3:0] CTRL_ALU_ADD  = 4'd0;
    localparam logic [3:0] CTRL_ALU_SUB  = 4'd1;
    localparam logic [3:0] CTRL_ALU_AND  = 4'd2;
    localparam logic [3:0] CTRL_ALU_OR   = 4'd3;
    localparam logic [3:0] CTRL_ALU_SHR  = 4'd4;
    localparam logic [3:0] CTRL_ALU_SHRA = 4'd5;
    localparam logic [3:0] CTRL_ALU_SHL  = 4'd6;
    localparam logic [3:0] CTRL_ALU_ROR  = 4'd7;
    localparam logic [3:0] CTRL_ALU_ROL  = 4'd8;
    localparam logic [3:0] CTRL_ALU_MUL  = 4'd9;
    localparam logic [3:0] CTRL_ALU_DIV  = 4'd10;
    localparam logic [3:0] CTRL_ALU_NEG  = 4'd11;
    localparam logic [3:0] CTRL_ALU_NOT  = 4'd12;

    localparam int PC_NRST    = 4;
    localparam int PC_EN      = 3;
    localparam int PC_JMP     = 2;
    localparam int PC_LOADRA  = 1;
    localparam int PC_LOADIMM = 0;

    localparam int ALU_EN_RA  = 4;
    localparam int ALU_EN_RB  = 3;
    localparam int ALU_EN_RZH = 2;
    localparam int ALU_EN_RZL = 1;
    localparam int ALU_EN_RAS = 0;

    localparam int MUX_BIS  = 5;
    localparam int MUX_RZHS = 4;
    localparam int MUX_WBM  = 3;
    localparam int MUX_WBP  = 2;
    localparam int MUX_MAP  = 1;
    localparam int MUX_ASS  = 0;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode to ALU control / format / halt / legality decode
module alu_op_decode
    import alu_ctrl_sequencer_pkg::*;
(
    input  logic [4:0] op,
    output logic [3:0] alu_ctrl,
    output logic       is_imm,
    output logic       is_halt,
    output logic       is_legal
);

    always_comb begin
        alu_ctrl = CTRL_ALU_ADD;
        is_imm   = 1'b0;
        is_halt  = 1'b0;
        is_legal = 1'b1;
        case (op)
            OP_ADD:  alu_ctrl = CTRL_ALU_ADD;
            OP_SUB:  alu_ctrl = CTRL_ALU_SUB;
            OP_SHR:  alu_ctrl = CTRL_ALU_SHR;
            OP_SHRA: alu_ctrl = CTRL_ALU_SHRA;
            OP_SHL:  alu_ctrl = CTRL_ALU_SHL;
            OP_ROR:  alu_ctrl = CTRL_ALU_ROR;
            OP_ROL:  alu_ctrl = CTRL_ALU_ROL;
            OP_AND:  alu_ctrl = CTRL_ALU_AND;
            OP_OR:   alu_ctrl = CTRL_ALU_OR;
            OP_ADDI: begin alu_ctrl = CTRL_ALU_ADD; is_imm = 1'b1; end
            OP_ANDI: begin alu_ctrl = CTRL_ALU_AND; is_imm = 1'b1; end
            OP_ORI:  begin alu_ctrl = CTRL_ALU_OR;  is_imm = 1'b1; end
            OP_MUL:  alu_ctrl = CTRL_ALU_MUL;
            OP_DIV:  alu_ctrl = CTRL_ALU_DIV;
            OP_NEG:  alu_ctrl = CTRL_ALU_NEG;
            OP_NOT:  alu_ctrl = CTRL_ALU_NOT;
            OP_HALT: is_halt  = 1'b1;
            // branch, load/store and I/O opcodes land here and trap
            default: is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// rtl/alu_ctrl_sequencer.sv - T0..T4 control sequencer for ALU-class instructions
// Optional single-step input iStep when CTRL_SEQ_STEP_EN is defined.
module alu_ctrl_sequencer
    import alu_ctrl_sequencer_pkg::*;
#(
    parameter int IMM_W    = 19,
    parameter int WAIT_MAX = 15
) (
    input  logic        iClk,
    input  logic        nRst,
`ifdef CTRL_SEQ_STEP_EN
    input  logic        iStep,
`endif
    input  logic [31:0] iMemData,
    input  logic        iMemRdy,
    output logic        oMemRd,
    output logic [4:0]  oPC,
    output logic        oRF_Write,
    output logic [3:0]  oRF_AddrA,
    output logic [3:0]  oRF_AddrB,
    output logic [3:0]  oRF_AddrC,
    output logic        oRWB_en,
    output logic [3:0]  oALU_Ctrl,
    output logic [4:0]  oALU_en,
    output logic [5:0]  oMUX,
    output logic [31:0] oImm32,
    output logic        oHalt,
    output logic        oTrap
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [31:0]      ir;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       addr_a_q;
    logic [3:0]       addr_b_q;
    logic [3:0]       addr_c_q;
    logic [3:0]       alu_ctrl_q;
    logic [3:0]       dec_alu_ctrl;
    logic             dec_is_imm;
    logic             dec_is_halt;
    logic             dec_is_legal;
    logic             fetch_go;
    logic             accept;

    alu_op_decode u_dec (
        .op       (ir[IR_OP_HI:IR_OP_LO]),
        .alu_ctrl (dec_alu_ctrl),
        .is_imm   (dec_is_imm),
        .is_halt  (dec_is_halt),
        .is_legal (dec_is_legal)
    );

`ifdef CTRL_SEQ_STEP_EN
    logic step_q;
    logic step_armed;

    // A fresh step edge wins over consumption so a step landing on the accept cycle is not lost.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            step_q     <= 1'b0;
            step_armed <= 1'b0;
        end else begin
            step_q <= iStep;
            if (iStep && !step_q)
                step_armed <= 1'b1;
            else if (accept)
                step_armed <= 1'b0;
        end
    end

    assign fetch_go = step_armed;
`else
    assign fetch_go = 1'b1;
`endif

    assign accept = (state == S_FETCH) && fetch_go && iMemRdy;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    state_nx = S_FETCH;
            S_FETCH: begin
                if (accept)
                    state_nx = S_DECODE;
                else if (fetch_go && wait_cnt == CNT_W'(WAIT_MAX - 1))
                    state_nx = S_TRAP;
            end
            S_DECODE: begin
                if (dec_is_halt)
                    state_nx = S_HALT;
                else if (!dec_is_legal)
                    state_nx = S_TRAP;
                else
                    state_nx = S_EXEC;
            end
            S_EXEC:    state_nx = S_WBLATCH;
            S_WBLATCH: state_nx = S_WBWRITE;
            S_WBWRITE: state_nx = S_FETCH;
            default:   state_nx = state;
        endcase
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state      <= S_IDLE;
            ir         <= '0;
            wait_cnt   <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            addr_c_q   <= '0;
            alu_ctrl_q <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                ir <= iMemData;
            if (state == S_FETCH && fetch_go && !iMemRdy)
                wait_cnt <= wait_cnt + 1'b1;
            else if (state != S_FETCH || accept)
                wait_cnt <= '0;
            if (state == S_DECODE) begin
                addr_a_q <= ir[IR_RB_HI:IR_RB_LO];
                addr_b_q <= ir[IR_RC_HI:IR_RC_LO];
            end
            if (state == S_EXEC)
                alu_ctrl_q <= dec_alu_ctrl;
            if (state == S_WBWRITE)
                addr_c_q <= ir[IR_RA_HI:IR_RA_LO];
        end
    end

    // PC reset line follows nRst directly so the PC is held while the sequencer is in reset.
    always_comb begin
        oPC        = '0;
        oALU_en    = '0;
        oMUX       = '0;
        oMemRd     = 1'b0;
        oRF_Write  = 1'b0;
        oRWB_en    = 1'b0;
        oPC[PC_NRST]    = nRst;
        oPC[PC_EN]      = accept;
        oPC[PC_JMP]     = 1'b0;
        oPC[PC_LOADRA]  = 1'b0;
        oPC[PC_LOADIMM] = 1'b0;
        oALU_en[ALU_EN_RAS] = 1'b0;
        case (state)
            S_FETCH: begin
                oMemRd        = fetch_go;
                oMUX[MUX_MAP] = fetch_go;
            end
            S_DECODE: begin
                oALU_en[ALU_EN_RA] = 1'b1;
                oALU_en[ALU_EN_RB] = 1'b1;
                oMUX[MUX_BIS]      = dec_is_imm;
            end
            S_EXEC: begin
                oALU_en[ALU_EN_RZH] = 1'b1;
                oALU_en[ALU_EN_RZL] = 1'b1;
                oMUX[MUX_RZHS]      = 1'b0;
                oMUX[MUX_ASS]       = 1'b0;
                oMUX[MUX_WBM]       = 1'b0;
                oMUX[MUX_WBP]       = 1'b0;
            end
            S_WBLATCH: oRWB_en   = 1'b1;
            S_WBWRITE: oRF_Write = 1'b1;
            default: ;
        endcase
    end

    assign oRF_AddrA = (state == S_DECODE)  ? ir[IR_RB_HI:IR_RB_LO] : addr_a_q;
    assign oRF_AddrB = (state == S_DECODE)  ? ir[IR_RC_HI:IR_RC_LO] : addr_b_q;
    assign oRF_AddrC = (state == S_WBWRITE) ? ir[IR_RA_HI:IR_RA_LO] : addr_c_q;
    assign oALU_Ctrl = (state == S_EXEC)    ? dec_alu_ctrl          : alu_ctrl_q;
    assign oImm32    = {{(32 - IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign oHalt     = (state == S_HALT);
    assign oTrap     = (state == S_TRAP);

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// tb/tb_alu_ctrl_sequencer.sv - randomized self-checking bench for alu_ctrl_sequencer
module tb_alu_ctrl_sequencer;
    import alu_ctrl_sequencer_pkg::*;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_data = '0;
    logic        mem_rdy = 1'b0;
`ifdef CTRL_SEQ_STEP_EN
    logic        step = 1'b0;
`endif
    logic        mem_rd;
    logic [4:0]  pc;
    logic        rf_write;
    logic [3:0]  addr_a;
    logic [3:0]  addr_b;
    logic [3:0]  addr_c;
    logic        rwb_en;
    logic [3:0]  alu_ctrl;
    logic [4:0]  alu_en;
    logic [5:0]  mux;
    logic [31:0] imm32;
    logic        halt;
    logic        trap;

    int n_cmp = 0;
    int n_bad = 0;

    alu_ctrl_sequencer #(.IMM_W(19), .WAIT_MAX(WAIT_MAX)) dut (
        .iClk      (clk),
        .nRst      (rst_n),
`ifdef CTRL_SEQ_STEP_EN
        .iStep     (step),
`endif
        .iMemData  (mem_data),
        .iMemRdy   (mem_rdy),
        .oMemRd    (mem_rd),
        .oPC       (pc),
        .oRF_Write (rf_write),
        .oRF_AddrA (addr_a),
        .oRF_AddrB (addr_b),
        .oRF_AddrC (addr_c),
        .oRWB_en   (rwb_en),
        .oALU_Ctrl (alu_ctrl),
        .oALU_en   (alu_en),
        .oMUX      (mux),
        .oImm32    (imm32),
        .oHalt     (halt),
        .oTrap     (trap)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ISA table: opcode number -> ALU operation, format, legality.
    function automatic logic [3:0] ref_alu(input logic [4:0] op);
        case (op)
            5'd3, 5'd12:  return CTRL_ALU_ADD;
            5'd4:         return CTRL_ALU_SUB;
            5'd5:         return CTRL_ALU_SHR;
            5'd6:         return CTRL_ALU_SHRA;
            5'd7:         return CTRL_ALU_SHL;
            5'd8:         return CTRL_ALU_ROR;
            5'd9:         return CTRL_ALU_ROL;
            5'd10, 5'd13: return CTRL_ALU_AND;
            5'd11, 5'd14: return CTRL_ALU_OR;
            5'd15:        return CTRL_ALU_MUL;
            5'd16:        return CTRL_ALU_DIV;
            5'd17:        return CTRL_ALU_NEG;
            5'd18:        return CTRL_ALU_NOT;
            default:      return CTRL_ALU_ADD;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [4:0] op);
        return (op >= 5'd3) && (op <= 5'd18);
    endfunction

    function automatic bit ref_imm(input logic [4:0] op);
        return (op >= 5'd12) && (op <= 5'd14);
    endfunction

    function automatic logic [31:0] ref_sext(input logic [31:0] ins);
        logic signed [18:0] c;
        c = ins[18:0];
        return 32'(int'(c));
    endfunction

    function automatic logic [36:0] ctl_bus();
        return {mem_rd, pc, rf_write, addr_a, addr_b, addr_c, rwb_en, alu_ctrl, alu_en, mux, halt, trap};
    endfunction

    // Called 1 time unit after a negedge; holds reset for 3 time units, then expects IDLE then FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        mem_rdy = 1'b0;
        #1;
        check_val("rst_ctl", 64'(ctl_bus()), 64'(0));
        check_val("rst_imm", 64'(imm32), 64'(0));
        #2;
        rst_n = 1'b1;
        #1;
        check_val("idle_pc", 64'(pc), 64'(5'b10000));
        check_val("idle_rd", 64'(mem_rd), 64'(0));
        @(negedge clk); #1;
        check_val("post_rst_fetch", 64'({mem_rd, rf_write, trap, halt}), 64'(4'b1000));
    endtask

    // Enters in FETCH, one time unit after a negedge.
    task automatic do_instr(input logic [31:0] ins, input int waits, input bit stop_in_exec);
        logic [4:0] op;
        int en_cnt;
        int bad;
        op = ins[31:27];
        en_cnt = 0;
        for (int i = 0; i < waits; i++) begin
            mem_rdy = 1'b0;
            mem_data = $urandom;
            #1;
            check_val("wait_rd_en_trap", 64'({mem_rd, pc[3], trap}), 64'(3'b100));
            @(negedge clk);
        end
        mem_rdy = 1'b1;
        mem_data = ins;
        #1;
        check_val("fetch_pc", 64'(pc), 64'(5'b11000));
        check_val("fetch_mux", 64'(mux), 64'(6'b000010));
        en_cnt += int'(pc[3]);
        @(negedge clk);
        mem_rdy = 1'($urandom_range(0, 1));
        mem_data = $urandom;
        #1;
        en_cnt += int'(pc[3]);
        check_val("dec_addr_ab", 64'({addr_a, addr_b}), 64'({ins[22:19], ins[18:15]}));
        check_val("dec_alu_en", 64'(alu_en), 64'(5'b11000));
        check_val("dec_mux", 64'(mux), 64'({ref_imm(op), 5'b0}));
        check_val("dec_imm", 64'(imm32), 64'(ref_sext(ins)));
        check_val("dec_rd_wr", 64'({mem_rd, rf_write}), 64'(0));
        if (op == 5'd27) begin
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk); #1;
                if (!halt || mem_rd || rf_write || trap) bad++;
            end
            check_val("halt_sticky", 64'(bad), 64'(0));
            return;
        end
        if (!ref_legal(op)) begin
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                mem_rdy = 1'($urandom_range(0, 1));
                @(negedge clk); #1;
                if (!trap || mem_rd || rf_write || halt) bad++;
            end
            check_val("trap_sticky", 64'(bad), 64'(0));
            return;
        end
        @(negedge clk); #1;
        en_cnt += int'(pc[3]);
        check_val("exec_alu", 64'(alu_ctrl), 64'(ref_alu(op)));
        check_val("exec_en_mux", 64'({alu_en, mux}), 64'({5'b00110, 6'b0}));
        check_val("exec_wb", 64'({rwb_en, rf_write}), 64'(0));
        if (stop_in_exec) return;
        @(negedge clk); #1;
        en_cnt += int'(pc[3]);
        check_val("latch_wb", 64'({rwb_en, rf_write, alu_en}), 64'({2'b10, 5'b0}));
        @(negedge clk); #1;
        en_cnt += int'(pc[3]);
        check_val("write_rf", 64'({rf_write, rwb_en, addr_c}), 64'({2'b10, ins[26:23]}));
        check_val("write_held", 64'({addr_a, addr_b, alu_ctrl}), 64'({ins[22:19], ins[18:15], ref_alu(op)}));
        check_val("pc_en_pulses", 64'(en_cnt), 64'(1));
        mem_rdy = 1'b0;
        @(negedge clk); #1;
        check_val("next_fetch", 64'({mem_rd, rf_write}), 64'(2'b10));
    endtask

    task automatic do_timeout();
        for (int i = 0; i < WAIT_MAX; i++) begin
            mem_rdy = 1'b0;
            #1;
            check_val("to_wait", 64'({mem_rd, trap}), 64'(2'b10));
            @(negedge clk);
        end
        #1;
        check_val("to_trap", 64'({trap, mem_rd, rf_write}), 64'(3'b100));
    endtask

    function automatic logic [31:0] rand_legal();
        logic [4:0] op;
        op = 5'($urandom_range(3, 18));
        return {op, 27'($urandom)};
    endfunction

    initial begin
        logic [4:0] bad_op;
        int w;
        @(negedge clk); #1;
        do_reset();

        do_instr({5'd9, 4'd4, 4'd3, 4'd7, 15'd0}, 0, 1'b0);
        do_instr({5'd3, 4'd5, 4'd6, 4'd2, 15'h1234}, 3, 1'b0);
        do_instr({5'd12, 4'd2, 4'd1, 19'h7FFFB}, 0, 1'b0);
        do_instr({5'd4, 4'd0, 4'd15, 4'd15, 15'd0}, WAIT_MAX - 1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WAIT_MAX - 1)) : 0;
            do_instr(rand_legal(), w, 1'b0);
        end

        do_instr(rand_legal(), 1, 1'b1);
        do_reset();

        bad_op = 5'($urandom_range(19, 31));
        if (bad_op == 5'd27) bad_op = 5'd0;
        do_instr({bad_op, 27'($urandom)}, 0, 1'b0);
        do_reset();

        do_timeout();
        do_reset();

        do_instr({5'd27, 27'($urandom)}, 2, 1'b0);
        do_reset();
        do_instr(rand_legal(), 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
- Control-unit sequencer for the ALU-class subset of the Mini SRC ISA. It drives the datapath's control inputs, the same signals a datapath bench drives by hand.
- Fetches the instruction word from memory into an internal IR and decodes R-format and I-format ALU instructions.
- For each instruction it issues the T0–T4 control pattern: fetch, operand load, execute, write-back latch, register-file write.
- Sits between the memory interface and the existing Datapath module. Branch, load/store and I/O instructions are out of scope; they trap as illegal.

Parameters:
- IMM_W, 19, width of the C field; it is sign-extended to 32 bits on oImm32.
- WAIT_MAX, 15, maximum number of memory wait cycles tolerated in FETCH before a timeout trap.

Ports:
- iClk  in  1  clock; all state changes on the rising edge.
- nRst  in  1  asynchronous, active-low reset.
- iMemData  in  32  instruction word from memory.
- iMemRdy  in  1  memory data valid this cycle.
- oMemRd  out  1  instruction read request; high in FETCH.
- oPC  out  5  {nRst, en, jmp, loadRA, loadImm}; maps to the Datapath iPC_* inputs.
- oRF_Write  out  1  register-file write enable.
- oRF_AddrA  out  4  read port A address (Rb field).
- oRF_AddrB  out  4  read port B address (Rc field).
- oRF_AddrC  out  4  write address (Ra field).
- oRWB_en  out  1  write-back register enable.
- oALU_Ctrl  out  4  ALU operation code.
- oALU_en  out  5  {RA, RB, RZH, RZL, RAS} register enables.
- oMUX  out  6  {BIS, RZHS, WBM, WBP, MAP, ASS} select lines.
- oImm32  out  32  sign-extended C field.
- oHalt  out  1  halt opcode retired; sticky.
- oTrap  out  1  illegal opcode or fetch timeout; sticky.

Behaviour:
- Reset (asynchronous, nRst=0):
  - state=IDLE, IR=0, wait counter=0.
  - Every output is 0, including oPC[4] (PC held in reset).
  - Reset asserted in any state, including mid-write-back, aborts the instruction with no RF write.
- Instruction format:
  - op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C=IR[18:0].
  - R-format: Ra ← Rb op Rc.
  - I-format (addi, andi, ori): Ra ← Rb op sext(C).
- States and transitions (one cycle each unless noted):
  - IDLE: oPC[4]=1; go to FETCH.
  - FETCH (T0):
    - oMemRd=1, MAP=1.
    - On iMemRdy=1: IR←iMemData, oPC en=1 for exactly that cycle, wait counter cleared, go to DECODE.
    - Otherwise stay in FETCH and increment the wait counter.
    - Counter reaching WAIT_MAX: go to TRAP.
  - DECODE (T1):
    - AddrA=Rb, AddrB=Rc, RA_en=RB_en=1.
    - BIS=1 for I-format (oImm32 valid), BIS=0 for R-format.
    - Opcode checks: halt opcode → HALT; unknown opcode → TRAP; otherwise → EXEC.
  - EXEC (T2): oALU_Ctrl=decoded op; RZH_en=RZL_en=1; RZHS=ASS=WBM=WBP=0.
  - WBLATCH (T3): RWB_en=1.
  - WBWRITE (T4): AddrC=Ra, oRF_Write=1; go to FETCH.
  - HALT: oHalt=1; exits only by reset.
  - TRAP: oTrap=1; exits only by reset; no RF write ever issued.
- Timing and output rules:
  - Latency with zero-wait memory: 5 cycles per instruction. Each memory wait cycle adds 1.
  - Enable outputs are single-cycle pulses, decoded combinationally from the registered state (Moore).
  - Address and ALU-control outputs hold their last value between uses.
- Edge cases:
  - Writes to Ra=0 are permitted; R0 semantics belong to the register file.
  - oImm32 is always sext(IR[18:0]), including for R-format instructions.
  - iMemRdy is ignored outside FETCH.

Optional Feature:
- Macro CTRL_SEQ_STEP_EN.
- Defined: adds input iStep. FETCH does not raise oMemRd until a rising edge of iStep has been seen, so the sequencer executes one instruction per step. The wait counter does not run while awaiting iStep.
- Undefined: no iStep port; free-running as above.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE, FETCH, DECODE, EXEC, WBLATCH, WBWRITE, HALT, TRAP);
  - IR field bit positions;
  - the opcode-to-CTRL_ALU mapping, reusing the existing ISA/ALU constants;
  - oPC, oALU_en and oMUX bit indices.
- One sub-module, alu_op_decode: combinational op → {ALU ctrl, isImm, isHalt, isLegal}.

Test Plan:
- Reset in EXEC: nRst low for 3 ns mid-EXEC → all outputs 0 immediately; no RF write follows; after release, IDLE then FETCH.
- rol R4,R3,R7 (R3=0x22, R7=0x24), zero-wait memory:
  - DECODE: AddrA=3, AddrB=7.
  - EXEC: ALU_Ctrl=CTRL_ALU_ROL.
  - WBWRITE: AddrC=4, RF_Write=1, on cycle 5.
  - With Datapath attached, R4=0x220.
- iMemRdy low for 3 cycles in FETCH → oPC en stays 0 until ready, one pulse afterwards; instruction completes in 8 cycles.
- addi R2,R1,-5 (C=0x7FFFB) → oImm32=0xFFFFFFFB and BIS=1 in DECODE; RF write to R2.
- Unknown opcode → oTrap=1 from the cycle after DECODE, no oRF_Write pulse, stays trapped for 20 cycles. iMemRdy held low for WAIT_MAX cycles → oTrap=1.
- Halt opcode → oHalt=1 sticky, oMemRd=0 thereafter. With CTRL_SEQ_STEP_EN, two iStep pulses → exactly two instructions retired.
